// File: rtl/instr_fetch_queue.sv
// ---------------------------------------------------------------------------
// instr_fetch_queue
//
// Purpose:
//   Instruction fetch front end. Issues sequential word fetches to an
//   instruction memory and keeps the returned words, each with its PC, in
//   an in-order queue that decode drains. A redirect flushes the queue,
//   restarts fetching at the new target, and quietly discards any memory
//   responses that were still in flight when it happened.
//
//   A queue slot is reserved when a request is accepted, so a response that
//   is not being discarded always has a slot waiting for it. The request
//   credit counts occupied slots plus every in-flight response, including
//   responses that will be dropped. That keeps the number of in-flight
//   requests bounded by DEPTH even right after a redirect.
//
// Parameters:
//   RESET_PC  first fetch address after reset
//   DEPTH     number of queue entries (power of two, >= 2)
//
// Ports:
//   clock            sole clock, all state updates on the rising edge
//   reset            synchronous, active-high
//   imem_req_valid   fetch request to instruction memory
//   imem_req_ready   memory accepts the request this cycle
//   imem_req_addr    word-aligned fetch address
//   imem_resp_valid  returned instruction word is valid (in order)
//   imem_resp_data   returned instruction word
//   redirect_valid   branch/jump taken: flush and refetch
//   redirect_pc      new fetch address (low two bits ignored)
//   out_valid        head entry available to decode
//   out_ready        decode consumes the head entry this cycle
//   out_instr        head instruction word
//   out_pc           address of out_instr
// ---------------------------------------------------------------------------
module instr_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   slot_pc    [DEPTH];
  logic [31:0]   slot_instr [DEPTH];

  // rd_ptr: head slot; wr_ptr: slot the next live response fills;
  // alloc_ptr: slot the next accepted request reserves.
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] alloc_ptr;

  // occupancy counts slots holding a returned word; outstanding counts every
  // response still owed by memory; drop_count is the subset to discard.
  logic [CW-1:0] occupancy;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_count;

  logic [CW:0]   in_use;
  logic          credit_ok;
  logic          req_fire;
  logic          resp_arrive;
  logic          resp_drop;
  logic          resp_write;
  logic          deq;

  assign in_use    = {1'b0, occupancy} + {1'b0, outstanding};
  assign credit_ok = (in_use < DEPTH_C);

  // Outputs are gated by reset combinationally so they are defined during
  // the first reset cycle, before the synchronous reset has taken effect.
  assign imem_req_valid = !reset && !redirect_valid && credit_ok;
  assign imem_req_addr  = reset ? RESET_PC : fetch_pc;
  assign out_valid      = !reset && (occupancy != '0);
  assign out_instr      = out_valid ? slot_instr[rd_ptr] : '0;
  assign out_pc         = out_valid ? slot_pc[rd_ptr]    : '0;

  // A response with nothing outstanding is stray and ignored. A response in
  // a redirect cycle still arrives (memory considers it delivered) but is
  // never written.
  assign req_fire    = imem_req_valid && imem_req_ready;
  assign resp_arrive = !reset && imem_resp_valid && (outstanding != '0);
  assign resp_drop   = resp_arrive && (drop_count != '0);
  assign resp_write  = resp_arrive && !redirect_valid && (drop_count == '0);
  assign deq         = out_valid && out_ready;

  // Control state: fetch address, pointers and counters. Redirect wins over
  // request, response and dequeue. The in-flight responses left after this
  // cycle all become drops.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      alloc_ptr   <= '0;
      occupancy   <= '0;
      outstanding <= '0;
      drop_count  <= '0;
    end else if (redirect_valid) begin
      fetch_pc    <= redirect_pc & 32'hFFFF_FFFC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      alloc_ptr   <= '0;
      occupancy   <= '0;
      outstanding <= outstanding - CW'(resp_arrive);
      drop_count  <= outstanding - CW'(resp_arrive);
    end else begin
      if (req_fire) begin
        fetch_pc  <= fetch_pc + 32'd4;
        alloc_ptr <= alloc_ptr + PW'(1);
      end
      if (resp_write) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      outstanding <= outstanding + CW'(req_fire) - CW'(resp_arrive);
      drop_count  <= drop_count - CW'(resp_drop);
      occupancy   <= occupancy + CW'(resp_write) - CW'(deq);
    end
  end

  // Slot storage. The PC is recorded when the slot is reserved. The word
  // lands when its response returns. Responses come back in order, so
  // wr_ptr always trails alloc_ptr onto the matching slot.
  always_ff @(posedge clock) begin
    if (req_fire) begin
      slot_pc[alloc_ptr] <= fetch_pc;
    end
    if (resp_write) begin
      slot_instr[wr_ptr] <= imem_resp_data;
    end
  end

  // Structural invariants of the counters.
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (outstanding <= CW'(DEPTH));
      assert (occupancy <= CW'(DEPTH));
      assert (drop_count <= outstanding);
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_queue
//
// Directed bench for instr_fetch_queue (DEPTH=4, RESET_PC=0). A small
// memory model answers each accepted request one cycle later with the word
// word_at(addr). It can be held off to build up in-flight requests, and it
// can inject a stray response. Inputs change 1 time unit after the rising
// edge. The memory model acts 2 units after the edge. Outputs are sampled
// on the falling edge.
// ---------------------------------------------------------------------------
module tb_instr_fetch_queue;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  int tests_run    = 0;
  int tests_failed = 0;

  logic        mem_hold;
  logic        mem_inject;
  logic [31:0] pend [$];
  logic        acc;
  logic [31:0] acc_addr;
  logic        presented_real;

  always #5 clock = ~clock;

  instr_fetch_queue #(
    .RESET_PC (RESET_PC),
    .DEPTH    (4)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_pc          (out_pc)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'h5EED_0000;
  endfunction

  // Memory model: one-cycle latency, in order, flushed by reset.
  initial begin : memory_model
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    presented_real  = 1'b0;
    forever begin
      @(negedge clock);
      acc      = imem_req_valid && imem_req_ready;
      acc_addr = imem_req_addr;
      @(posedge clock);
      #2;
      if (reset) begin
        pend.delete();
      end else begin
        if (presented_real && pend.size() > 0) void'(pend.pop_front());
        if (acc) pend.push_back(acc_addr);
      end
      presented_real = 1'b0;
      if (!reset && !mem_hold && pend.size() > 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = word_at(pend[0]);
        presented_real  = 1'b1;
      end else if (!reset && mem_inject) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hDEAD_BEEF;
      end else begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    @(negedge clock);
    tests_run++;
    if (imem_req_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_req_valid: got %0b expected 0", imem_req_valid);
    end
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_out_valid: got %0b expected 0", out_valid);
    end
    tests_run++;
    if (imem_req_addr !== RESET_PC) begin
      tests_failed++;
      $display("[TB] FAIL reset_req_addr: got %h expected %h", imem_req_addr, RESET_PC);
    end
    tests_run++;
    if (out_instr !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_out_instr: got %h expected 0", out_instr);
    end
    tests_run++;
    if (out_pc !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_out_pc: got %h expected 0", out_pc);
    end
    tick();
    reset = 1'b0;
    @(negedge clock);
    tests_run++;
    if (imem_req_valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL release_req_valid: got %0b expected 1", imem_req_valid);
    end
    tests_run++;
    if (imem_req_addr !== RESET_PC) begin
      tests_failed++;
      $display("[TB] FAIL release_req_addr: got %h expected %h", imem_req_addr, RESET_PC);
    end
  endtask

  task automatic test_streaming();
    logic [31:0] exp_pc;
    imem_req_ready = 1'b1;
    out_ready      = 1'b1;
    mem_hold       = 1'b0;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      tests_run++;
      if (out_valid !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL stream_latency cycle %0d: got out_valid %0b expected 0", i, out_valid);
      end
    end
    exp_pc = 32'h0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      tests_run++;
      if (out_valid !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL stream_valid %0d: got %0b expected 1", i, out_valid);
      end
      tests_run++;
      if (out_pc !== exp_pc) begin
        tests_failed++;
        $display("[TB] FAIL stream_pc %0d: got %h expected %h", i, out_pc, exp_pc);
      end
      tests_run++;
      if (out_instr !== word_at(exp_pc)) begin
        tests_failed++;
        $display("[TB] FAIL stream_instr %0d: got %h expected %h", i, out_instr, word_at(exp_pc));
      end
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_backpressure();
    int          accepts;
    logic [31:0] exp_pc;
    out_ready      = 1'b0;
    imem_req_ready = 1'b1;
    mem_hold       = 1'b0;
    do_reset();
    accepts = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (imem_req_valid && imem_req_ready) accepts++;
    end
    tests_run++;
    if (accepts != 4) begin
      tests_failed++;
      $display("[TB] FAIL bp_accepts: got %0d expected 4", accepts);
    end
    tests_run++;
    if (imem_req_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL bp_req_stopped: got %0b expected 0", imem_req_valid);
    end
    tests_run++;
    if (out_valid !== 1'b1 || out_instr !== word_at(32'h0)) begin
      tests_failed++;
      $display("[TB] FAIL bp_head: got valid %0b instr %h expected 1 %h", out_valid, out_instr, word_at(32'h0));
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      tests_run++;
      if (out_pc !== 32'h0) begin
        tests_failed++;
        $display("[TB] FAIL bp_hold_pc %0d: got %h expected 0", i, out_pc);
      end
    end
    tick();
    out_ready = 1'b1;
    exp_pc = 32'h0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      tests_run++;
      if (out_valid !== 1'b1 || out_pc !== exp_pc) begin
        tests_failed++;
        $display("[TB] FAIL bp_drain %0d: got valid %0b pc %h expected 1 %h", i, out_valid, out_pc, exp_pc);
      end
      if (i == 1) begin
        tests_run++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h10) begin
          tests_failed++;
          $display("[TB] FAIL bp_resume: got valid %0b addr %h expected 1 00000010", imem_req_valid, imem_req_addr);
        end
      end
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  or_pat;
    logic [4:0]  rq_pat;
    logic [6:0]  hd_pat;
    logic [31:0] exp_pc;
    logic [31:0] held_pc;
    logic        stall_prev;
    int          accepts;
    int          deqs;
    or_pat = 8'b1011_0110;
    rq_pat = 5'b11010;
    hd_pat = 7'b0100100;
    out_ready      = 1'b0;
    imem_req_ready = 1'b1;
    mem_hold       = 1'b0;
    do_reset();
    accepts = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (imem_req_valid && imem_req_ready) accepts++;
    end
    tests_run++;
    if (imem_req_valid !== 1'b0 || out_valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL b2b_full: got req_valid %0b out_valid %0b expected 0 1", imem_req_valid, out_valid);
    end
    exp_pc     = 32'h0;
    deqs       = 0;
    stall_prev = 1'b0;
    held_pc    = '0;
    for (int i = 0; i < 40; i++) begin
      tick();
      out_ready      = or_pat[i % 8];
      imem_req_ready = rq_pat[i % 5];
      mem_hold       = hd_pat[i % 7];
      @(negedge clock);
      if (stall_prev) begin
        tests_run++;
        if (out_pc !== held_pc) begin
          tests_failed++;
          $display("[TB] FAIL b2b_stable %0d: got %h expected %h", i, out_pc, held_pc);
        end
      end
      if (imem_req_valid && imem_req_ready) accepts++;
      if (out_valid && out_ready) begin
        tests_run++;
        if (out_pc !== exp_pc || out_instr !== word_at(exp_pc)) begin
          tests_failed++;
          $display("[TB] FAIL b2b_order %0d: got pc %h instr %h expected %h %h", i, out_pc, out_instr, exp_pc, word_at(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
        deqs++;
      end
      stall_prev = out_valid && !out_ready;
      held_pc    = out_pc;
    end
    tick();
    out_ready      = 1'b1;
    imem_req_ready = 1'b0;
    mem_hold       = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (out_valid) begin
        tests_run++;
        if (out_pc !== exp_pc) begin
          tests_failed++;
          $display("[TB] FAIL b2b_drain %0d: got %h expected %h", i, out_pc, exp_pc);
        end
        exp_pc = exp_pc + 32'd4;
        deqs++;
      end
    end
    tests_run++;
    if (deqs < 8) begin
      tests_failed++;
      $display("[TB] FAIL b2b_throughput: got %0d dequeues expected at least 8", deqs);
    end
    tests_run++;
    if (deqs != accepts || out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_conserve: got %0d dequeues, out_valid %0b expected %0d, 0", deqs, out_valid, accepts);
    end
  endtask

  task automatic test_redirect();
    logic found;
    out_ready      = 1'b1;
    imem_req_ready = 1'b1;
    mem_hold       = 1'b1;
    do_reset();
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    @(negedge clock);
    tests_run++;
    if (imem_req_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL redir_withdraw: got %0b expected 0", imem_req_valid);
    end
    tick();
    redirect_valid = 1'b0;
    mem_hold       = 1'b0;
    @(negedge clock);
    tests_run++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_0100) begin
      tests_failed++;
      $display("[TB] FAIL redir_next_req: got valid %0b addr %h expected 1 00000100", imem_req_valid, imem_req_addr);
    end
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clock);
      if (out_valid) found = 1'b1;
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("[TB] FAIL redir_timeout: got no out_valid expected one within 12 cycles");
    end
    tests_run++;
    if (out_pc !== 32'h0000_0100 || out_instr !== word_at(32'h100)) begin
      tests_failed++;
      $display("[TB] FAIL redir_first_out: got pc %h instr %h expected 00000100 %h", out_pc, out_instr, word_at(32'h100));
    end
    @(negedge clock);
    tests_run++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0000_0104) begin
      tests_failed++;
      $display("[TB] FAIL redir_second_out: got valid %0b pc %h expected 1 00000104", out_valid, out_pc);
    end
  endtask

  task automatic test_wrap();
    logic        found;
    logic [31:0] wrap_exp [4];
    wrap_exp[0] = 32'hFFFF_FFF8;
    wrap_exp[1] = 32'hFFFF_FFFC;
    wrap_exp[2] = 32'h0000_0000;
    wrap_exp[3] = 32'h0000_0004;
    out_ready      = 1'b1;
    imem_req_ready = 1'b1;
    mem_hold       = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF9;
    tick();
    redirect_valid = 1'b0;
    @(negedge clock);
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL wrap_flush: got out_valid %0b expected 0", out_valid);
    end
    tests_run++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFF8) begin
      tests_failed++;
      $display("[TB] FAIL wrap_req: got valid %0b addr %h expected 1 fffffff8", imem_req_valid, imem_req_addr);
    end
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (i > 0) @(negedge clock);
      if (out_valid) found = 1'b1;
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("[TB] FAIL wrap_timeout: got no out_valid expected one within 12 cycles");
    end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clock);
      tests_run++;
      if (out_valid !== 1'b1 || out_pc !== wrap_exp[i] || out_instr !== word_at(wrap_exp[i])) begin
        tests_failed++;
        $display("[TB] FAIL wrap_seq %0d: got valid %0b pc %h instr %h expected 1 %h %h", i, out_valid, out_pc, out_instr, wrap_exp[i], word_at(wrap_exp[i]));
      end
    end
  endtask

  task automatic test_stray_response();
    logic found;
    imem_req_ready = 1'b0;
    out_ready      = 1'b1;
    mem_hold       = 1'b0;
    mem_inject     = 1'b1;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      tests_run++;
      if (out_valid !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL stray_ignored %0d: got out_valid %0b expected 0", i, out_valid);
      end
    end
    tick();
    mem_inject     = 1'b0;
    imem_req_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clock);
      if (out_valid) found = 1'b1;
    end
    tests_run++;
    if (!found || out_pc !== 32'h0 || out_instr !== word_at(32'h0)) begin
      tests_failed++;
      $display("[TB] FAIL stray_first_out: got found %0b pc %h instr %h expected 1 00000000 %h", found, out_pc, out_instr, word_at(32'h0));
    end
  endtask

  task automatic test_reset_midstream();
    out_ready      = 1'b0;
    imem_req_ready = 1'b1;
    mem_hold       = 1'b0;
    mem_inject     = 1'b0;
    do_reset();
    tick();
    tick();
    tick();
    imem_req_ready = 1'b0;
    tick();
    tick();
    @(negedge clock);
    tests_run++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || imem_req_addr !== 32'h0000_000C) begin
      tests_failed++;
      $display("[TB] FAIL mid_queued: got valid %0b pc %h addr %h expected 1 00000000 0000000c", out_valid, out_pc, imem_req_addr);
    end
    tick();
    reset = 1'b1;
    @(negedge clock);
    tests_run++;
    if (out_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset_outputs: got out_valid %0b req_valid %0b expected 0 0", out_valid, imem_req_valid);
    end
    tick();
    reset          = 1'b0;
    imem_req_ready = 1'b1;
    @(negedge clock);
    tests_run++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC || out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL mid_restart: got req_valid %0b addr %h out_valid %0b expected 1 %h 0", imem_req_valid, imem_req_addr, out_valid, RESET_PC);
    end
  endtask

  initial begin : main
    reset          = 1'b1;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;
    mem_hold       = 1'b0;
    mem_inject     = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_back_to_back();
    test_redirect();
    test_wrap();
    test_stray_response();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
